up_reg_slave: RTL and testbench
===============================

UP_REG_SLAVE -- requirements
Module: up_reg_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h0000; block is selected when up_addr[15:8] == BASE_ADDR[15:8].
REQ-002 SHALL have parameter ID_VALUE, default 32'h55AA_0001; value returned by the ID register.
REQ-003 SHALL have port up_clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port up_rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port up_csn, input, 1: chip select, active low (negative logic).
REQ-006 SHALL have port up_wbe, input, 1: write enable, active low; high = read.
REQ-007 SHALL have port up_addr, input, [15:2]: word address.
REQ-008 SHALL have port up_data_io, inout, 32: bidirectional data bus; driven only during a selected read, else high-Z.
REQ-009 SHALL have port ctrl_out, output, 32: live value of general register 0.
REQ-010 SHALL have port wr_pulse, output, 1: one-cycle pulse per committed write.

Function
REQ-011 SHALL decode offset = {up_addr[7:2],2'b00}: 0x00-0x3C general RW regs 0-15; 0x40 ID (RO); 0x44 WR_CNT (RO); 0x48 RD_CNT (RO); 0x4C CLR (write-only; reads 0).
REQ-012 SHALL use FSM states IDLE, WRITE, READ, HOLD; one transaction per csn-low assertion.
REQ-013 IDLE: csn sampled low, hit, wbe low -> WRITE; hit, wbe high -> READ; miss -> HOLD; else stay.
REQ-014 WRITE: data on up_data_io committed at the posedge that samples csn low (cycle N); wr_pulse high during cycle N+1; csn held low -> HOLD, no re-commit.
REQ-015 READ: data snapshotted at posedge N; output enable registered high from N+1 until the posedge that samples csn high; that posedge returns to IDLE and releases the bus.
REQ-016 HOLD: no drive, no commit; csn sampled high -> IDLE.
REQ-017 Back-to-back: csn high for a single sampled cycle between accesses SHALL suffice for a new transaction.
REQ-018 Writes to RO offsets, 0x50-0xFC, or reads of unmapped offsets: write ignored (no wr_pulse); read returns 32'h0000_0000.
REQ-019 WR_CNT SHALL increment on each committed write to a general register; RD_CNT on each hit read; both 32-bit, wrap 0xFFFF_FFFF -> 0.
REQ-020 Read of RD_CNT SHALL return the pre-increment value.
REQ-021 Write of any data to CLR SHALL zero both counters at N+1; that write is not counted; wr_pulse still asserted.
REQ-022 Address miss SHALL never drive up_data_io or change any state except the FSM.
REQ-023 ctrl_out SHALL update the cycle after a commit to offset 0x00.

Reset
REQ-024 up_rst high SHALL immediately (asynchronously) release up_data_io to high-Z, force IDLE, zero regs 0-15, counters, ctrl_out, wr_pulse.
REQ-025 Reset mid-transaction SHALL abort it; after deassert, csn still low SHALL be treated as a new access starting at next sampling edge.

Structure
REQ-026 Package up_reg_pkg SHALL hold FSM state typedef, offset constants (0x40/0x44/0x48/0x4C), NUM_GP_REGS=16, unmapped read value.
REQ-027 Storage SHALL be sub-module up_reg_file (16x32, one write port, one async read port, async reset); FSM, counters, tristate in top.
REQ-028 Tristate SHALL be a single continuous assign from registered enable and registered data.

Verification
REQ-029 Reset, write 0x00=0x1234_5678 -> ctrl_out=0x1234_5678 at N+1, wr_pulse one cycle, WR_CNT=1.
REQ-030 Read 0x40 csn low 3 cycles -> bus driven ID_VALUE cycles N+1..N+3, high-Z after csn high, RD_CNT=1.
REQ-031 Write 0x3C=0xA5A5_A5A5 then read 0x3C -> 0xA5A5_A5A5; read 0x50 -> 0x0; write 0x44 -> WR_CNT unchanged, no wr_pulse.
REQ-032 up_addr[15:8] != BASE -> bus high-Z throughout, counters unchanged.
REQ-033 Two reads, write CLR, read 0x48 -> 0x0; read 0x48 again -> 0x1.
REQ-034 Assert up_rst during READ drive -> bus high-Z same cycle, reg 0 = 0, FSM IDLE.

Source files
------------

// File: rtl/up_reg_pkg.sv
// Shared types and constants for the up_reg_slave register block.
package up_reg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StHold
  } state_e;

  localparam int unsigned NUM_GP_REGS = 16;

  localparam logic [7:0] OffId    = 8'h40;
  localparam logic [7:0] OffWrCnt = 8'h44;
  localparam logic [7:0] OffRdCnt = 8'h48;
  localparam logic [7:0] OffClr   = 8'h4C;

  localparam logic [31:0] UnmappedRdata = 32'h0000_0000;

endpackage

// File: rtl/up_reg_file.sv
// 16x32 general-purpose register storage: one write port, one async read port,
// plus a dedicated tap of register 0.
module up_reg_file
  import up_reg_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [3:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  raddr_i,
  output logic [31:0] rdata_o,
  output logic [31:0] reg0_o
);

  logic [31:0] regs_q [NUM_GP_REGS];
  logic [31:0] regs_d [NUM_GP_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we_i) begin
      regs_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_o = regs_q[raddr_i];
  assign reg0_o  = regs_q[0];

endmodule

// File: rtl/up_reg_slave.sv
// Microprocessor-bus register slave: 16 RW regs, ID, write/read counters and a
// counter-clear register behind a csn/wbe handshake with a tristate data bus.
module up_reg_slave
  import up_reg_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [31:0] ID_VALUE  = 32'h55AA_0001
) (
  input  logic        up_clk,
  input  logic        up_rst,
  input  logic        up_csn,
  input  logic        up_wbe,
  input  logic [15:2] up_addr,
  inout  wire  [31:0] up_data_io,
  output logic [31:0] ctrl_out,
  output logic        wr_pulse
);

  state_e      state_q, state_d;
  logic        oe_q, oe_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wr_pulse_q, wr_pulse_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;

  logic [7:0]  offset;
  logic        hit;
  logic        is_gp;
  logic        gp_we;
  logic [31:0] gp_rdata;
  logic [31:0] rdata_mux;

  assign offset = {up_addr[7:2], 2'b00};
  assign hit    = (up_addr[15:8] == BASE_ADDR[15:8]);
  assign is_gp  = (offset[7:6] == 2'b00);

  up_reg_file u_reg_file (
    .clk_i   (up_clk),
    .rst_i   (up_rst),
    .we_i    (gp_we),
    .waddr_i (up_addr[5:2]),
    .wdata_i (up_data_io),
    .raddr_i (up_addr[5:2]),
    .rdata_o (gp_rdata),
    .reg0_o  (ctrl_out)
  );

  always_comb begin
    rdata_mux = UnmappedRdata;
    if (is_gp) begin
      rdata_mux = gp_rdata;
    end else begin
      case (offset)
        OffId:    rdata_mux = ID_VALUE;
        OffWrCnt: rdata_mux = wr_cnt_q;
        OffRdCnt: rdata_mux = rd_cnt_q;
        default:  rdata_mux = UnmappedRdata;
      endcase
    end
  end

  // Only a sampled csn-low edge in StIdle may start, commit or count anything.
  always_comb begin
    state_d    = state_q;
    oe_d       = oe_q;
    rdata_d    = rdata_q;
    wr_pulse_d = 1'b0;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    gp_we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!up_csn) begin
          if (!hit) begin
            state_d = StHold;
          end else if (!up_wbe) begin
            state_d = StWrite;
            if (is_gp) begin
              gp_we      = 1'b1;
              wr_pulse_d = 1'b1;
              wr_cnt_d   = wr_cnt_q + 32'd1;
            end else if (offset == OffClr) begin
              wr_pulse_d = 1'b1;
              wr_cnt_d   = '0;
              rd_cnt_d   = '0;
            end
          end else begin
            state_d  = StRead;
            oe_d     = 1'b1;
            rdata_d  = rdata_mux;
            rd_cnt_d = rd_cnt_q + 32'd1;
          end
        end
      end
      StWrite: state_d = up_csn ? StIdle : StHold;
      StRead: begin
        if (up_csn) begin
          state_d = StIdle;
          oe_d    = 1'b0;
        end
      end
      StHold: begin
        if (up_csn) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      state_q    <= StIdle;
      oe_q       <= 1'b0;
      rdata_q    <= '0;
      wr_pulse_q <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      oe_q       <= oe_d;
      rdata_q    <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  assign wr_pulse   = wr_pulse_q;
  assign up_data_io = oe_q ? rdata_q : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_up_reg_slave.sv
// Scoreboard bench for up_reg_slave: stimulus queues expected bus events, a
// negedge monitor pops and compares them as the DUT pulses or drives the bus.
module tb_up_reg_slave;

  localparam logic [31:0] Released = 32'hFFFF_FFFF;

  logic        up_clk = 1'b0;
  logic        up_rst;
  logic        up_csn;
  logic        up_wbe;
  logic [15:2] up_addr;
  tri1  [31:0] up_data_io;
  logic [31:0] ctrl_out;
  logic        wr_pulse;

  logic        tb_drv_en;
  logic [31:0] tb_wdata;

  // Pulled-up bus: an undriven bus reads all ones.
  assign up_data_io = tb_drv_en ? tb_wdata : 32'hzzzz_zzzz;

  always #5 up_clk = ~up_clk;

  up_reg_slave #(
    .BASE_ADDR (16'h0000),
    .ID_VALUE  (32'h55AA_0001)
  ) dut (
    .up_clk     (up_clk),
    .up_rst     (up_rst),
    .up_csn     (up_csn),
    .up_wbe     (up_wbe),
    .up_addr    (up_addr),
    .up_data_io (up_data_io),
    .ctrl_out   (ctrl_out),
    .wr_pulse   (wr_pulse)
  );

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    int          ncyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit is_rd, input logic [31:0] data, input int ncyc);
    exp_t e;
    e.is_rd = is_rd;
    e.data  = data;
    e.ncyc  = ncyc;
    exp_q.push_back(e);
  endtask

  bit          prev_drv = 1'b0;
  bit          prev_pulse = 1'b0;
  logic [31:0] cur_data;
  int          cur_ncyc;
  int          cyc;

  always @(negedge up_clk) begin
    bit   drv;
    exp_t e;
    if (up_rst) begin
      prev_drv   = 1'b0;
      prev_pulse = 1'b0;
    end else begin
      drv = !tb_drv_en && (up_data_io !== Released);
      if (wr_pulse) begin
        checks++;
        if (prev_pulse) begin
          errors++;
          $display("FAIL wr_pulse_width: got high 2+ cycles expected 1 at %0t", $time);
        end else if (exp_q.size() == 0 || exp_q[0].is_rd) begin
          errors++;
          $display("FAIL unexpected_wr_pulse: got pulse expected none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
        end
      end
      if (drv && !prev_drv) begin
        checks++;
        cur_data = up_data_io;
        cur_ncyc = 0;
        cyc      = 1;
        if (exp_q.size() == 0 || !exp_q[0].is_rd) begin
          errors++;
          $display("FAIL unexpected_bus_drive: got %h expected high-Z at %0t", up_data_io, $time);
        end else begin
          e = exp_q.pop_front();
          chk("read_data", up_data_io, e.data);
          cur_data = e.data;
          cur_ncyc = e.ncyc;
        end
      end else if (drv) begin
        cyc++;
        chk("read_data_stable", up_data_io, cur_data);
      end else if (prev_drv && cur_ncyc > 0) begin
        chk("read_drive_cycles", cyc, cur_ncyc);
      end
      prev_drv   = drv;
      prev_pulse = wr_pulse;
    end
  end

  task automatic tick;
    @(posedge up_clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d);
    bit commit;
    commit = (a[15:8] == 8'h00) && ((a[7:0] < 8'h40) || (a[7:0] == 8'h4C));
    if (commit) push(1'b0, d, 0);
    up_addr   = a[15:2];
    up_wbe    = 1'b0;
    up_csn    = 1'b0;
    tb_wdata  = d;
    tb_drv_en = 1'b1;
    tick;
    @(negedge up_clk);
    #1;
    if (a == 16'h0000) chk("ctrl_out_after_commit", ctrl_out, d);
    up_csn    = 1'b1;
    up_wbe    = 1'b1;
    tb_drv_en = 1'b0;
    tick;
  endtask

  task automatic do_read(input logic [15:0] a, input int ncyc, input bit exp_drv,
                         input logic [31:0] exp);
    if (exp_drv) push(1'b1, exp, ncyc);
    up_addr = a[15:2];
    up_wbe  = 1'b1;
    up_csn  = 1'b0;
    repeat (ncyc) tick;
    up_csn = 1'b1;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    up_rst    = 1'b1;
    up_csn    = 1'b1;
    up_wbe    = 1'b1;
    up_addr   = '0;
    tb_drv_en = 1'b0;
    tb_wdata  = '0;
    repeat (3) @(posedge up_clk);
    @(negedge up_clk);
    chk("reset_ctrl_out", ctrl_out, 32'h0);
    chk("reset_wr_pulse", {31'b0, wr_pulse}, 32'h0);
    chk("reset_bus_released", up_data_io, Released);
    @(posedge up_clk);
    #1 up_rst = 1'b0;
    tick;

    // Basic write, counter and ID reads.
    do_write(16'h0000, 32'h1234_5678);
    do_read(16'h0044, 1, 1'b1, 32'd1);
    do_read(16'h0040, 3, 1'b1, 32'h55AA_0001);
    chk("bus_released_after_read", up_data_io, Released);
    do_write(16'h003C, 32'hA5A5_A5A5);
    do_read(16'h003C, 2, 1'b1, 32'hA5A5_A5A5);
    do_read(16'h0050, 1, 1'b1, 32'h0);
    do_write(16'h0044, 32'hDEAD_BEEF);
    do_read(16'h0044, 1, 1'b1, 32'd2);

    // Block miss: no drive, no commit, no counting.
    do_read(16'h0100, 3, 1'b0, 32'h0);
    chk("miss_bus_released", up_data_io, Released);
    do_write(16'h0100, 32'h0BAD_0BAD);
    do_read(16'h0048, 1, 1'b1, 32'd5);
    do_read(16'h0000, 1, 1'b1, 32'h1234_5678);
    do_read(16'h0044, 1, 1'b1, 32'd2);

    // Counter clear.
    do_read(16'h0004, 1, 1'b1, 32'h0);
    do_write(16'h004C, 32'h0000_0001);
    do_read(16'h0048, 1, 1'b1, 32'd0);
    do_read(16'h0048, 1, 1'b1, 32'd1);
    do_read(16'h0044, 1, 1'b1, 32'd0);

    // Back-to-back writes, then readback.
    do_write(16'h0008, 32'h1111_2222);
    do_write(16'h000C, 32'h3333_4444);
    do_read(16'h0008, 1, 1'b1, 32'h1111_2222);
    do_read(16'h000C, 1, 1'b1, 32'h3333_4444);
    do_read(16'h004C, 1, 1'b1, 32'h0);
    do_read(16'h0044, 1, 1'b1, 32'd2);
    do_read(16'h003C, 1, 1'b1, 32'hA5A5_A5A5);

    // Reset while the bus is driven; csn stays low through deassert.
    push(1'b1, 32'h1234_5678, 0);
    up_addr = 14'h0000;
    up_wbe  = 1'b1;
    up_csn  = 1'b0;
    tick;
    @(negedge up_clk);
    #1 up_rst = 1'b1;
    #1;
    chk("reset_mid_read_bus", up_data_io, Released);
    chk("reset_mid_read_reg0", ctrl_out, 32'h0);
    chk("reset_mid_read_pulse", {31'b0, wr_pulse}, 32'h0);
    push(1'b1, 32'h0, 1);
    @(posedge up_clk);
    #1 up_rst = 1'b0;
    tick;
    up_csn = 1'b1;
    tick;
    do_read(16'h0048, 1, 1'b1, 32'd1);
    do_read(16'h003C, 1, 1'b1, 32'h0);

    repeat (3) tick;
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
